// File: rtl/fe_timestamp_gen_pkg.sv
// Shared FIFO entry command codes and timestamp field widths
// for the trace capture front-end.
package fe_timestamp_gen_pkg;

    localparam int FE_FIFO_SHORTTIME_LEN = 8;
    localparam int FE_FIFO_FULLTIME_LEN  = 16;

    localparam logic [1:0] FE_FIFO_CMD_DATA = 2'd0;
    localparam logic [1:0] FE_FIFO_CMD_STAT = 2'd1;
    localparam logic [1:0] FE_FIFO_CMD_TIME = 2'd2;

    typedef logic [1:0] fe_cmd_t;

endpackage

// File: rtl/fe_timestamp_gen_counter.sv
// Elapsed-time counter: load-to-1, increment, hold-zero,
// all-ones detect and short-timestamp fit check.
module fe_time_counter #(
    parameter int FW = 16,
    parameter int SW = 8
) (
    input  logic          trace_clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [15:0]   i_max_short,
    output logic [FW-1:0] o_cnt,
    output logic          o_all_ones,
    output logic          o_fits
);

    logic [FW-1:0] r_cnt;
    logic [SW-1:0] w_max_eff;
    logic          w_clamp;

    // Any bit above the short field means the limit exceeds the field.
    always_comb begin
        w_clamp   = |i_max_short[15:SW];
        w_max_eff = w_clamp ? {SW{1'b1}} : i_max_short[SW-1:0];
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= {{(FW-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt + {{(FW-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt      = r_cnt;
    assign o_all_ones = &r_cnt;
    assign o_fits     = (r_cnt[FW-1:SW] == '0) &&
                        (r_cnt[SW-1:0] <= w_max_eff);

endmodule

// File: rtl/fe_timestamp_gen.sv
// Front-end timestamp/command generator feeding the trace
// capture FIFO write logic (trace_clk domain).
module fe_timestamp_gen
    import fe_timestamp_gen_pkg::*;
#(
    parameter int pTIMESTAMP_FULL_WIDTH  = FE_FIFO_FULLTIME_LEN,
    parameter int pTIMESTAMP_SHORT_WIDTH = FE_FIFO_SHORTTIME_LEN
) (
    input  logic                             trace_clk,
    input  logic                             reset,
    input  logic                             I_arm,
    input  logic                             I_event,
    input  logic [1:0]                       I_data_cmd,
    input  logic [15:0]                      I_max_short_timestamp,
    input  logic                             I_fifo_full,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
    output logic [1:0]                       O_fifo_command,
    output logic                             O_fifo_wr,
    output logic                             O_capturing,
    output logic                             O_stopped_full,
    output logic                             O_event_dropped
);

    localparam int FW = pTIMESTAMP_FULL_WIDTH;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_STOPPED = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        CAPTURE = ST_CAPTURE,
        HOLD    = ST_HOLD,
        STOPPED = ST_STOPPED
    } state_t;

    state_t        r_state;
    logic          r_wr;
    logic [FW-1:0] r_time;
    fe_cmd_t       r_cmd;
    fe_cmd_t       r_pend_cmd;
    logic          r_capturing;
    logic          r_stopped_full;
    logic          r_event_dropped;

    logic [FW-1:0] w_cnt;
    logic          w_all_ones;
    logic          w_fits;
    logic          w_load;
    logic          w_clear;

    fe_time_counter #(
        .FW (FW),
        .SW (pTIMESTAMP_SHORT_WIDTH)
    ) u_cnt (
        .trace_clk   (trace_clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_max_short (I_max_short_timestamp),
        .o_cnt       (w_cnt),
        .o_all_ones  (w_all_ones),
        .o_fits      (w_fits)
    );

    // Counter restarts at 1 on every issued entry; zero outside capture.
    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                w_load  = I_arm;
                w_clear = !I_arm;
            end
            CAPTURE: begin
                if (I_fifo_full || !I_arm) begin
                    w_clear = 1'b1;
                end else begin
                    w_load = I_event || w_all_ones;
                end
            end
            HOLD: begin
                w_clear = I_fifo_full || !I_arm;
                w_load  = !(I_fifo_full || !I_arm);
            end
            default: begin
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_wr            <= 1'b0;
            r_time          <= '0;
            r_cmd           <= '0;
            r_pend_cmd      <= '0;
            r_capturing     <= 1'b0;
            r_stopped_full  <= 1'b0;
            r_event_dropped <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_time <= '0;
            r_cmd  <= '0;
            unique case (r_state)
                IDLE: begin
                    if (I_arm) begin
                        r_state         <= CAPTURE;
                        r_capturing     <= 1'b1;
                        r_stopped_full  <= 1'b0;
                        r_event_dropped <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (I_fifo_full) begin
                        r_state        <= STOPPED;
                        r_capturing    <= 1'b0;
                        r_stopped_full <= 1'b1;
                    end else if (!I_arm) begin
                        r_state     <= IDLE;
                        r_capturing <= 1'b0;
                    end else if (I_event) begin
                        r_wr   <= 1'b1;
                        r_time <= w_cnt;
                        if (w_fits) begin
                            r_cmd <= I_data_cmd;
                        end else begin
                            r_cmd      <= FE_FIFO_CMD_TIME;
                            r_pend_cmd <= I_data_cmd;
                            r_state    <= HOLD;
                        end
                    end else if (w_all_ones) begin
                        r_wr   <= 1'b1;
                        r_time <= w_cnt;
                        r_cmd  <= FE_FIFO_CMD_TIME;
                    end
                end
                HOLD: begin
                    if (I_event) begin
                        r_event_dropped <= 1'b1;
                    end
                    if (I_fifo_full) begin
                        r_state        <= STOPPED;
                        r_capturing    <= 1'b0;
                        r_stopped_full <= 1'b1;
                    end else begin
                        r_wr  <= 1'b1;
                        r_cmd <= r_pend_cmd;
                        if (I_arm) begin
                            r_state <= CAPTURE;
                        end else begin
                            r_state     <= IDLE;
                            r_capturing <= 1'b0;
                        end
                    end
                end
                STOPPED: begin
                    if (!I_arm) begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign O_fifo_time     = r_time;
    assign O_fifo_command  = r_cmd;
    assign O_fifo_wr       = r_wr;
    assign O_capturing     = r_capturing;
    assign O_stopped_full  = r_stopped_full;
    assign O_event_dropped = r_event_dropped;

endmodule

// File: tb/tb_fe_timestamp_gen.sv
// Bench for fe_timestamp_gen: cycle-time reference model plus
// directed scenarios with literal expectations.
module tb_fe_timestamp_gen;
    import fe_timestamp_gen_pkg::*;

    // Narrow counter so full-width idle records arrive quickly.
    localparam int FW   = 12;
    localparam int ALL1 = (1 << FW) - 1;

    logic          trace_clk = 1'b0;
    logic          reset     = 1'b1;
    logic          I_arm     = 1'b0;
    logic          I_event   = 1'b0;
    logic [1:0]    I_data_cmd = 2'd0;
    logic [15:0]   I_max_short_timestamp = 16'd255;
    logic          I_fifo_full = 1'b0;
    logic [FW-1:0] O_fifo_time;
    logic [1:0]    O_fifo_command;
    logic          O_fifo_wr;
    logic          O_capturing;
    logic          O_stopped_full;
    logic          O_event_dropped;

    fe_timestamp_gen #(
        .pTIMESTAMP_FULL_WIDTH (FW)
    ) dut (
        .trace_clk             (trace_clk),
        .reset                 (reset),
        .I_arm                 (I_arm),
        .I_event               (I_event),
        .I_data_cmd            (I_data_cmd),
        .I_max_short_timestamp (I_max_short_timestamp),
        .I_fifo_full           (I_fifo_full),
        .O_fifo_time           (O_fifo_time),
        .O_fifo_command        (O_fifo_command),
        .O_fifo_wr             (O_fifo_wr),
        .O_capturing           (O_capturing),
        .O_stopped_full        (O_stopped_full),
        .O_event_dropped       (O_event_dropped)
    );

    always #5 trace_clk = ~trace_clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_wr     = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: elapsed time is the distance in clock edges
    // between the current edge and the edge of the last issued entry.
    typedef enum int {M_IDLE, M_CAP, M_HOLD, M_STOP} mode_t;
    mode_t mode = M_IDLE;
    int    cyc = 0;
    int    t_last = 0;
    int    el, lim;
    logic  [1:0] pend = 2'd0;
    logic  m_started = 1'b0;
    logic  e_wr = 1'b0, e_cap = 1'b0, e_stop = 1'b0, e_drop = 1'b0;
    int    e_time = 0;
    logic  [1:0] e_cmd = 2'd0;

    task automatic emit(input int t, input logic [1:0] c);
        e_wr   = 1'b1;
        e_time = t;
        e_cmd  = c;
        t_last = cyc;
    endtask

    task automatic model_step();
        m_started = 1'b1;
        cyc++;
        e_wr = 1'b0;
        e_time = 0;
        e_cmd = 2'd0;
        if (reset) begin
            mode = M_IDLE;
            e_stop = 1'b0;
            e_drop = 1'b0;
        end else begin
            el  = cyc - t_last;
            lim = (int'(I_max_short_timestamp) < 255) ?
                  int'(I_max_short_timestamp) : 255;
            case (mode)
                M_IDLE: if (I_arm) begin
                    mode = M_CAP;
                    t_last = cyc;
                    e_stop = 1'b0;
                    e_drop = 1'b0;
                end
                M_CAP: begin
                    if (I_fifo_full) begin
                        mode = M_STOP;
                        e_stop = 1'b1;
                    end else if (!I_arm) begin
                        mode = M_IDLE;
                    end else if (I_event && el <= lim) begin
                        emit(el, I_data_cmd);
                    end else if (I_event) begin
                        emit(el, FE_FIFO_CMD_TIME);
                        pend = I_data_cmd;
                        mode = M_HOLD;
                    end else if (el == ALL1) begin
                        emit(ALL1, FE_FIFO_CMD_TIME);
                    end
                end
                M_HOLD: begin
                    if (I_event) e_drop = 1'b1;
                    if (I_fifo_full) begin
                        mode = M_STOP;
                        e_stop = 1'b1;
                    end else begin
                        emit(0, pend);
                        mode = I_arm ? M_CAP : M_IDLE;
                    end
                end
                default: if (!I_arm) mode = M_IDLE;
            endcase
        end
        e_cap = (mode == M_CAP) || (mode == M_HOLD);
    endtask

    always @(posedge trace_clk) model_step();

    always @(negedge trace_clk) begin
        if (m_started) begin
            if (O_fifo_wr) n_wr++;
            chk("m_wr", 32'(O_fifo_wr), 32'(e_wr));
            if (e_wr) begin
                chk("m_time", 32'(O_fifo_time), 32'(e_time));
                chk("m_cmd", 32'(O_fifo_command), 32'(e_cmd));
            end
            chk("m_capturing", 32'(O_capturing), 32'(e_cap));
            chk("m_stopped", 32'(O_stopped_full), 32'(e_stop));
            chk("m_dropped", 32'(O_event_dropped), 32'(e_drop));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge trace_clk);
    endtask

    task automatic ev(input logic [1:0] c);
        I_event = 1'b1;
        I_data_cmd = c;
        @(negedge trace_clk);
        I_event = 1'b0;
    endtask

    task automatic entry(input string nm, input int t, input logic [1:0] c);
        chk({nm, "_wr"}, 32'(O_fifo_wr), 32'd1);
        chk({nm, "_time"}, 32'(O_fifo_time), 32'(t));
        chk({nm, "_cmd"}, 32'(O_fifo_command), 32'(c));
    endtask

    task automatic rearm();
        I_arm = 1'b0;
        @(negedge trace_clk);
        I_arm = 1'b1;
        @(negedge trace_clk);
    endtask

    int base;

    initial begin
        idle(3);
        chk("rst_wr", 32'(O_fifo_wr), 32'd0);
        chk("rst_time", 32'(O_fifo_time), 32'd0);
        chk("rst_cap", 32'(O_capturing), 32'd0);
        reset = 1'b0;
        idle(2);

        // short entry, latency one cycle
        rearm();
        chk("arm_cap", 32'(O_capturing), 32'd1);
        idle(4);
        ev(FE_FIFO_CMD_STAT);
        entry("short5", 5, FE_FIFO_CMD_STAT);
        idle(1);
        chk("short5_once", 32'(O_fifo_wr), 32'd0);

        // over-limit event: TIME then DATA, then next short
        rearm();
        idle(299);
        ev(FE_FIFO_CMD_DATA);
        entry("long_time", 300, FE_FIFO_CMD_TIME);
        idle(1);
        entry("long_data", 0, FE_FIFO_CMD_DATA);
        idle(9);
        ev(FE_FIFO_CMD_STAT);
        entry("after_pair", 10, FE_FIFO_CMD_STAT);

        // idle overflow records
        rearm();
        idle(ALL1);
        entry("ovf1", ALL1, FE_FIFO_CMD_TIME);
        idle(ALL1);
        entry("ovf2", ALL1, FE_FIFO_CMD_TIME);

        // event coinciding with all-ones count
        rearm();
        idle(ALL1 - 1);
        ev(FE_FIFO_CMD_STAT);
        entry("sim_time", ALL1, FE_FIFO_CMD_TIME);
        idle(1);
        entry("sim_data", 0, FE_FIFO_CMD_STAT);
        idle(1);
        chk("sim_no_extra", 32'(O_fifo_wr), 32'd0);

        // limit clamped to 255
        I_max_short_timestamp = 16'h0400;
        rearm();
        idle(254);
        ev(FE_FIFO_CMD_DATA);
        entry("clamp255", 255, FE_FIFO_CMD_DATA);
        idle(255);
        ev(FE_FIFO_CMD_STAT);
        entry("clamp256_t", 256, FE_FIFO_CMD_TIME);
        idle(1);
        entry("clamp256_d", 0, FE_FIFO_CMD_STAT);

        // event during HOLD is dropped
        I_max_short_timestamp = 16'd10;
        rearm();
        idle(19);
        ev(FE_FIFO_CMD_STAT);
        entry("hold_t", 20, FE_FIFO_CMD_TIME);
        ev(FE_FIFO_CMD_DATA);
        entry("hold_d", 0, FE_FIFO_CMD_STAT);
        chk("dropped", 32'(O_event_dropped), 32'd1);
        idle(1);
        chk("drop_no_wr", 32'(O_fifo_wr), 32'd0);

        // FIFO full in HOLD discards pending DATA
        idle(14);
        ev(FE_FIFO_CMD_DATA);
        entry("full_t", 16, FE_FIFO_CMD_TIME);
        I_fifo_full = 1'b1;
        @(negedge trace_clk);
        I_fifo_full = 1'b0;
        chk("full_no_data", 32'(O_fifo_wr), 32'd0);
        chk("stopped", 32'(O_stopped_full), 32'd1);
        chk("stop_cap", 32'(O_capturing), 32'd0);
        base = n_wr;
        repeat (5) begin
            idle(3);
            ev(FE_FIFO_CMD_DATA);
        end
        chk("stop_silent", 32'(n_wr - base), 32'd0);
        rearm();
        chk("rearm_stop", 32'(O_stopped_full), 32'd0);
        chk("rearm_drop", 32'(O_event_dropped), 32'd0);

        // reset while in HOLD
        I_max_short_timestamp = 16'd255;
        idle(299);
        ev(FE_FIFO_CMD_DATA);
        entry("rsth_t", 300, FE_FIFO_CMD_TIME);
        reset = 1'b1;
        @(negedge trace_clk);
        reset = 1'b0;
        chk("rsth_wr", 32'(O_fifo_wr), 32'd0);
        chk("rsth_time", 32'(O_fifo_time), 32'd0);
        chk("rsth_cmd", 32'(O_fifo_command), 32'd0);
        chk("rsth_cap", 32'(O_capturing), 32'd0);
        @(negedge trace_clk);
        idle(6);
        ev(FE_FIFO_CMD_STAT);
        entry("rsth_rearm", 7, FE_FIFO_CMD_STAT);

        I_arm = 1'b0;
        idle(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
